// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Multi-cycle LEGv8 sequencer (Moore FSM) driving the shared
//            execute stage and the register-file, memory and PC enables.
//            Optional retired-instruction counter behind MC_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller #(
    parameter int OPW  = 11
`ifdef MC_RETIRE_CNT_EN
    ,
    parameter int CNTW = 32
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           memReady,
    output logic           instrRead,
    output logic           irWrite,
    output logic           pcWrite,
    output logic           pcBranch,
    output logic           AluSrc,
    output logic [3:0]     AluControl,
    output logic           memRead,
    output logic           memWrite,
    output logic           regWrite,
    output logic           memtoReg,
    output logic           reg2loc,
    output logic           illegal
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [CNTW-1:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_LDUR = 3'd0,
        K_STUR = 3'd1,
        K_ADD  = 3'd2,
        K_SUB  = 3'd3,
        K_AND  = 3'd4,
        K_ORR  = 3'd5,
        K_CBZ  = 3'd6,
        K_ILL  = 3'd7
    } iclass_t;

    typedef struct packed {
        logic       instr_read;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg2loc;
    } ctrl_t;

    localparam logic [OPW-1:0] c_op_ldur   = 11'b11111000010;
    localparam logic [OPW-1:0] c_op_stur   = 11'b11111000000;
    localparam logic [OPW-1:0] c_op_add    = 11'b10001011000;
    localparam logic [OPW-1:0] c_op_sub    = 11'b11001011000;
    localparam logic [OPW-1:0] c_op_and    = 11'b10001010000;
    localparam logic [OPW-1:0] c_op_orr    = 11'b10101010000;
    localparam logic [7:0]     c_op_cbz_hi = 8'b10110100;

    localparam logic [3:0] c_alu_add  = 4'b0010;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_orr  = 4'b0001;
    localparam logic [3:0] c_alu_pass = 4'b0111;

    function automatic iclass_t decode_op(input logic [OPW-1:0] op);
        iclass_t k;
        k = K_ILL;
        if (op == c_op_ldur)                   k = K_LDUR;
        else if (op == c_op_stur)              k = K_STUR;
        else if (op == c_op_add)               k = K_ADD;
        else if (op == c_op_sub)               k = K_SUB;
        else if (op == c_op_and)               k = K_AND;
        else if (op == c_op_orr)               k = K_ORR;
        else if (op[OPW-1 -: 8] == c_op_cbz_hi) k = K_CBZ;
        return k;
    endfunction

    function automatic logic [3:0] alu_op(input iclass_t k);
        logic [3:0] a;
        case (k)
            K_SUB:   a = c_alu_sub;
            K_AND:   a = c_alu_and;
            K_ORR:   a = c_alu_orr;
            default: a = c_alu_add;
        endcase
        return a;
    endfunction

    // Moore decode of a state/class pair; MEM keeps the EXEC ALU setup.
    function automatic ctrl_t moore_ctrl(input state_t s, input iclass_t k);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = c_alu_add;
        case (s)
            S_FETCH: c.instr_read = 1'b1;
            S_EXEC: begin
                c.alu_src  = (k == K_LDUR) || (k == K_STUR);
                c.alu_ctrl = alu_op(k);
                c.reg2loc  = (k == K_STUR);
            end
            S_MEM: begin
                c.alu_src   = (k == K_LDUR) || (k == K_STUR);
                c.alu_ctrl  = alu_op(k);
                c.mem_read  = (k == K_LDUR);
                c.mem_write = (k == K_STUR);
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (k == K_LDUR);
            end
            S_BRANCH: begin
                c.reg2loc  = 1'b1;
                c.alu_ctrl = c_alu_pass;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t  state_q, state_d;
    iclass_t class_q, class_d;
    ctrl_t   ctrl_q;
    logic    illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                class_d = decode_op(opcode);
                if (class_d == K_CBZ) begin
                    state_d = S_BRANCH;
                end else if (class_d == K_ILL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((class_q == K_LDUR) || (class_q == K_STUR)) state_d = S_MEM;
                else                                             state_d = S_WB;
            end
            S_MEM: begin
                if (memReady) state_d = (class_q == K_LDUR) ? S_WB : S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they change with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= K_ILL;
            ctrl_q    <= moore_ctrl(S_FETCH, K_ILL);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            ctrl_q    <= moore_ctrl(state_d, class_d);
            illegal_q <= illegal_d;
        end
    end

    logic w_fetch_done;
    assign w_fetch_done = (state_q == S_FETCH) && memReady && !reset;

    assign instrRead  = ctrl_q.instr_read;
    assign irWrite    = w_fetch_done;
    assign pcWrite    = w_fetch_done;
    assign pcBranch   = (state_q == S_BRANCH) && zero;
    assign AluSrc     = ctrl_q.alu_src;
    assign AluControl = ctrl_q.alu_ctrl;
    assign memRead    = ctrl_q.mem_read;
    assign memWrite   = ctrl_q.mem_write;
    assign regWrite   = ctrl_q.reg_write;
    assign memtoReg   = ctrl_q.mem_to_reg;
    assign reg2loc    = ctrl_q.reg2loc;
    assign illegal    = illegal_q;

`ifdef MC_RETIRE_CNT_EN
    logic            w_retire;
    logic [CNTW-1:0] retired_q;

    assign w_retire = (state_q == S_WB) || (state_q == S_BRANCH) ||
                      ((state_q == S_MEM) && memReady && (class_q == K_STUR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         retired_q <= '0;
        else if (w_retire) retired_q <= retired_q + CNTW'(1);
    end

    assign retired = retired_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Randomized self-checking bench for mc_controller against a
//            per-instruction phase-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset, zero, memReady;
    logic [10:0] opcode;
    logic        instrRead, irWrite, pcWrite, pcBranch, AluSrc;
    logic [3:0]  AluControl;
    logic        memRead, memWrite, regWrite, memtoReg, reg2loc, illegal;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    mc_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .instrRead(instrRead), .irWrite(irWrite), .pcWrite(pcWrite), .pcBranch(pcBranch),
        .AluSrc(AluSrc), .AluControl(AluControl), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .memtoReg(memtoReg), .reg2loc(reg2loc), .illegal(illegal)
`ifdef MC_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_BRANCH, P_HALT} phase_t;
    typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_ILL} kind_t;

    int total = 0;
    int bad   = 0;
    int model_retired = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] observed();
        return {instrRead, irWrite, pcWrite, pcBranch, AluSrc, AluControl,
                memRead, memWrite, regWrite, memtoReg, reg2loc, illegal};
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table.
    function automatic logic [14:0] expect_outs(input phase_t p, input kind_t k,
                                                input logic [3:0] aop, input bit mr, input bit z);
        logic ir = 0, irw = 0, pcb = 0, src = 0, mrd = 0, mwr = 0, rw = 0, m2r = 0, r2l = 0, ill = 0;
        logic [3:0] ac = 4'b0010;
        case (p)
            P_FETCH:  begin ir = 1; irw = mr; end
            P_EXEC:   begin src = (k == K_LD || k == K_ST); ac = (k == K_R) ? aop : 4'b0010; r2l = (k == K_ST); end
            P_MEM:    begin src = 1; mrd = (k == K_LD); mwr = (k == K_ST); end
            P_WB:     begin rw = 1; m2r = (k == K_LD); end
            P_BRANCH: begin r2l = 1; ac = 4'b0111; pcb = z; end
            P_HALT:   ill = 1;
            default:  ;
        endcase
        return {ir, irw, irw, pcb, src, ac, mrd, mwr, rw, m2r, r2l, ill};
    endfunction

    function automatic bit is_legal(input logic [10:0] op);
        return op == 11'b11111000010 || op == 11'b11111000000 || op == 11'b10001011000 ||
               op == 11'b11001011000 || op == 11'b10001010000 || op == 11'b10101010000 ||
               op[10:3] == 8'b10110100;
    endfunction

    task automatic do_reset();
        reset = 1'b1; memReady = 1'b1; zero = 1'b1;
        #1 check_eq("rst_async", 32'(observed()), 32'(expect_outs(P_FETCH, K_R, 4'b0010, 1'b0, 1'b0)));
        @(posedge clk); #1;
        check_eq("rst_hold", 32'(observed()), 32'(expect_outs(P_FETCH, K_R, 4'b0010, 1'b0, 1'b0)));
        model_retired = 0;
`ifdef MC_RETIRE_CNT_EN
        check_eq("rst_retired", retired, 32'd0);
`endif
        reset = 1'b0; memReady = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one instruction; entered 1 time unit after the edge that starts FETCH.
    task automatic run_instr(input logic [10:0] op, input kind_t k, input logic [3:0] aop,
                             input int fst, input int mst, input bit abort_mem);
        phase_t ph[$];
        bit     mr[$];
        bit     z;
        string  tag;
`ifdef MC_RETIRE_CNT_EN
        check_eq("retired", retired, 32'(model_retired));
`endif
        for (int i = 0; i <= fst; i++) begin ph.push_back(P_FETCH); mr.push_back(i == fst); end
        ph.push_back(P_DECODE); mr.push_back(1'($urandom));
        if (k != K_CBZ && k != K_ILL) begin ph.push_back(P_EXEC); mr.push_back(1'($urandom)); end
        if (k == K_LD || k == K_ST)
            for (int i = 0; i <= mst; i++) begin ph.push_back(P_MEM); mr.push_back(i == mst); end
        if (k == K_R || k == K_LD) begin ph.push_back(P_WB); mr.push_back(1'($urandom)); end
        if (k == K_CBZ) begin ph.push_back(P_BRANCH); mr.push_back(1'($urandom)); end
        if (k == K_ILL) for (int i = 0; i < 20; i++) begin ph.push_back(P_HALT); mr.push_back(1'($urandom)); end

        opcode = op;
        for (int c = 0; c < ph.size(); c++) begin
            z = 1'($urandom);
            memReady = mr[c];
            zero = z;
            #1;
            tag = $sformatf("outs_k%0d_c%0d", int'(k), c);
            check_eq(tag, 32'(observed()), 32'(expect_outs(ph[c], k, aop, mr[c], z)));
            if (abort_mem && ph[c] == P_MEM && !mr[c]) begin
                #1 reset = 1'b1;
                #1 check_eq("rst_mid_mem", 32'(observed()),
                            32'(expect_outs(P_FETCH, K_R, 4'b0010, 1'b0, 1'b0)));
                do_reset();
                return;
            end
            @(posedge clk); #1;
        end
        if (k == K_ILL) begin
`ifdef MC_RETIRE_CNT_EN
            check_eq("retired_ill", retired, 32'(model_retired));
`endif
            do_reset();
            check_eq("ill_cleared", 32'(illegal), 32'd0);
        end else begin
            model_retired++;
        end
    endtask

    task automatic random_instr();
        int          r;
        logic [10:0] op;
        logic [3:0]  aop;
        kind_t       k;
        r   = $urandom_range(0, 9);
        aop = 4'b0010;
        case (r)
            0: begin op = 11'b10001011000; k = K_R; aop = 4'b0010; end
            1: begin op = 11'b11001011000; k = K_R; aop = 4'b0110; end
            2: begin op = 11'b10001010000; k = K_R; aop = 4'b0000; end
            3: begin op = 11'b10101010000; k = K_R; aop = 4'b0001; end
            4: begin op = 11'b11111000010; k = K_LD; end
            5, 9: begin op = 11'b11111000000; k = K_ST; end
            6, 7: begin op = {8'b10110100, 3'($urandom)}; k = K_CBZ; end
            default: begin
                op = 11'($urandom);
                while (is_legal(op)) op = 11'($urandom);
                k = K_ILL;
            end
        endcase
        run_instr(op, k, aop, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 3), (r == 9) && ($urandom_range(0, 1) == 1));
    endtask

    initial begin
        reset = 1'b0; memReady = 1'b0; zero = 1'b0; opcode = '0;
        #1;
        do_reset();
        run_instr(11'b10001011000, K_R,   4'b0010, 0, 0, 1'b0);
        run_instr(11'b11111000010, K_LD,  4'b0010, 0, 3, 1'b0);
        run_instr(11'b10110100101, K_CBZ, 4'b0010, 0, 0, 1'b0);
        run_instr(11'b10110100000, K_CBZ, 4'b0010, 2, 0, 1'b0);
        run_instr(11'b11111000000, K_ST,  4'b0010, 1, 2, 1'b0);
        run_instr(11'b00000000000, K_ILL, 4'b0010, 0, 0, 1'b0);
        run_instr(11'b11111000000, K_ST,  4'b0010, 0, 3, 1'b1);
        for (int i = 0; i < 5; i++) random_instr();
        run_instr(11'b11001011000, K_R, 4'b0110, 0, 0, 1'b0);
`ifdef MC_RETIRE_CNT_EN
        check_eq("retired_end", retired, 32'(model_retired));
`endif
        for (int i = 0; i < 150; i++) random_instr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
